// File: rtl/sonar_echo_rx.sv
// Sonar echo receiver: synchronizes the comparator output, looks for a run of
// in-tolerance tone periods after the blanking window and reports time-of-flight.
module sonar_echo_rx #(
    parameter int unsigned CLK_DIV    = 10,
    parameter int unsigned TOL        = 2,
    parameter int unsigned MIN_CYCLES = 4,
    parameter int unsigned BLANK      = 64,
    parameter int unsigned TIMEOUT    = 100000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             echo_in,
    output logic             busy,
    output logic [CNT_W-1:0] tof,
    output logic             tof_valid,
    output logic             timeout
);

    localparam int unsigned PERIOD = 2 * (CLK_DIV + 1);
    localparam int unsigned P_LO_I = (PERIOD > TOL + 1) ? (PERIOD - TOL) : 1;
    localparam int unsigned RUN_W  = $clog2(MIN_CYCLES + 1);

    localparam logic [CNT_W-1:0] P_LO      = CNT_W'(P_LO_I);
    localparam logic [CNT_W-1:0] P_HI      = CNT_W'(PERIOD + TOL);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] TO_END    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_GOAL  = RUN_W'(MIN_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_LISTEN
    } state_t;

    state_t           state;
    logic             sync1, sync2, sync3;
    logic [CNT_W-1:0] t;
    logic [CNT_W-1:0] first;
    logic [CNT_W-1:0] last;
    logic [RUN_W-1:0] run;
    logic             have_edge;

    logic             edge_det;
    logic [CNT_W-1:0] p;
    logic             in_tol;
    logic [RUN_W-1:0] run_inc;
    logic             detect;

    // NOTE: every signal gets a default before any condition, so no latch is inferred.
    always_comb begin
        edge_det = sync2 & ~sync3;
        p        = t - last;
        in_tol   = (p >= P_LO) && (p <= P_HI);
        run_inc  = run + RUN_W'(1);
        detect   = 1'b0;
        if (state == ST_LISTEN && edge_det && have_edge && in_tol && run_inc == RUN_GOAL)
            detect = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            t         <= '0;
            first     <= '0;
            last      <= '0;
            run       <= '0;
            have_edge <= 1'b0;
            busy      <= 1'b0;
            tof       <= '0;
            tof_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            sync1     <= echo_in;
            sync2     <= sync1;
            sync3     <= sync2;
            tof_valid <= 1'b0;
            timeout   <= 1'b0;

            if (state != ST_IDLE)
                t <= t + CNT_W'(1);

            case (state)
                ST_IDLE: ;
                ST_BLANK: begin
                    if (t == BLANK_END)
                        state <= ST_LISTEN;
                end
                ST_LISTEN: begin
                    if (edge_det) begin
                        last <= t;
                        if (!have_edge) begin
                            have_edge <= 1'b1;
                            first     <= t;
                            run       <= '0;
                        end else if (in_tol) begin
                            run <= run_inc;
                        end else begin
                            run   <= '0;
                            first <= t;
                        end
                    end
                    // Detection takes priority over a timeout landing on the same cycle.
                    if (detect) begin
                        tof       <= first;
                        tof_valid <= 1'b1;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end else if (t == TO_END) begin
                        tof     <= TO_VAL;
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A start always re-arms; any result decided this cycle still pulses.
            if (start) begin
                state     <= ST_BLANK;
                busy      <= 1'b1;
                t         <= '0;
                run       <= '0;
                have_edge <= 1'b0;
            end
        end
    end

endmodule
